// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: packs bytes into 32-bit words and writes NWORDS of them.
// Optional trailing checksum word is enabled with macro IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned NWORDS     = 64,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        we,
    output logic [5:0]  wa,
    output logic [31:0] wd,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StWrite,
        StCheck,
        StDone
    } state_e;

    // Counter is one bit wider than wa so it can reach NWORDS without wrapping.
    localparam logic [6:0] LastWord = 7'(NWORDS - 1);

    state_e      r_state;
    state_e      w_state_next;
    logic [6:0]  r_word_cnt;
    logic [1:0]  r_byte_cnt;
    logic [31:0] r_asm;
    logic [5:0]  r_wa;
    logic [31:0] r_wd;
    logic        w_accept;
    logic        w_last_byte;
    logic        w_start_load;
    logic        w_last_word;
    logic [1:0]  w_lane;
    logic [31:0] w_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign byte_ready = (r_state == StCollect) || (r_state == StCheck);
`else
    assign byte_ready = (r_state == StCollect);
`endif

    assign w_accept     = byte_valid && byte_ready;
    assign w_last_byte  = w_accept && (r_byte_cnt == 2'd3);
    assign w_start_load = start && ((r_state == StIdle) || (r_state == StDone));
    assign w_last_word  = (r_word_cnt == LastWord);
    assign w_lane       = BIG_ENDIAN ? ~r_byte_cnt : r_byte_cnt;

    // Word as it will look once the byte currently offered is merged in.
    always_comb begin
        w_word = r_asm;
        w_word[{w_lane, 3'b000} +: 8] = byte_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) w_state_next = StCollect;
            end
            StCollect: begin
                busy = 1'b1;
                if (w_last_byte) w_state_next = StWrite;
            end
            StWrite: begin
                busy = 1'b1;
                if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_state_next = StCheck;
`else
                    w_state_next = StDone;
`endif
                end else begin
                    w_state_next = StCollect;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            StCheck: begin
                busy = 1'b1;
                if (w_last_byte) w_state_next = StDone;
            end
`endif
            StDone: begin
                done = 1'b1;
                if (start) w_state_next = StCollect;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_word_cnt <= 7'd0;
            r_byte_cnt <= 2'd0;
            r_asm      <= 32'd0;
            r_wa       <= 6'd0;
            r_wd       <= 32'd0;
        end else begin
            if (w_start_load) begin
                r_word_cnt <= 7'd0;
                r_byte_cnt <= 2'd0;
                r_asm      <= 32'd0;
            end
            if (w_accept) begin
                r_asm      <= w_word;
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
            // wa/wd are captured here so they hold their value outside WRITE.
            if (w_last_byte && (r_state == StCollect)) begin
                r_wa <= r_word_cnt[5:0];
                r_wd <= w_word;
            end
            if (r_state == StWrite) begin
                r_word_cnt <= r_word_cnt + 7'd1;
            end
        end
    end

    assign we = (r_state == StWrite);
    assign wa = r_wa;
    assign wd = r_wd;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] r_acc;
    logic        r_error;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc   <= 32'd0;
            r_error <= 1'b0;
        end else if (w_start_load) begin
            r_acc   <= 32'd0;
            r_error <= 1'b0;
        end else begin
            if (r_state == StWrite) r_acc <= r_acc + r_wd;
            if ((r_state == StCheck) && w_last_byte) r_error <= (w_word != r_acc);
        end
    end

    assign error = r_error;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: three instances (2 words big/little endian, 64 words big endian).
// Builds with or without IMEM_LOADER_CHECKSUM_EN; trailers are sent only when it is defined.
module tb_imem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ready_in_write = 0;

    logic [2:0]  rst_v;
    logic [2:0]  start_v;
    logic [2:0]  bv_v;
    logic [7:0]  bd_v [3];
    logic [2:0]  ready_v;
    logic [2:0]  we_v;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [2:0]  error_v;
    logic [5:0]  wa_v [3];
    logic [31:0] wd_v [3];

    logic [37:0] log0[$];
    logic [37:0] log1[$];
    logic [37:0] log2[$];

    imem_loader #(.NWORDS(2), .BIG_ENDIAN(1'b1)) u_be (
        .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .byte_valid(bv_v[0]),
        .byte_data(bd_v[0]), .byte_ready(ready_v[0]), .we(we_v[0]), .wa(wa_v[0]),
        .wd(wd_v[0]), .busy(busy_v[0]), .done(done_v[0]), .error(error_v[0])
    );

    imem_loader #(.NWORDS(2), .BIG_ENDIAN(1'b0)) u_le (
        .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .byte_valid(bv_v[1]),
        .byte_data(bd_v[1]), .byte_ready(ready_v[1]), .we(we_v[1]), .wa(wa_v[1]),
        .wd(wd_v[1]), .busy(busy_v[1]), .done(done_v[1]), .error(error_v[1])
    );

    imem_loader #(.NWORDS(64), .BIG_ENDIAN(1'b1)) u_full (
        .clk(clk), .reset(rst_v[2]), .start(start_v[2]), .byte_valid(bv_v[2]),
        .byte_data(bd_v[2]), .byte_ready(ready_v[2]), .we(we_v[2]), .wa(wa_v[2]),
        .wd(wd_v[2]), .busy(busy_v[2]), .done(done_v[2]), .error(error_v[2])
    );

    always @(negedge clk) begin
        if (we_v[0]) log0.push_back({wa_v[0], wd_v[0]});
        if (we_v[1]) log1.push_back({wa_v[1], wd_v[1]});
        if (we_v[2]) log2.push_back({wa_v[2], wd_v[2]});
        for (int k = 0; k < 3; k++) begin
            if (we_v[k] && ready_v[k]) ready_in_write++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int k);
        start_v[k] = 1'b1;
        tick();
        start_v[k] = 1'b0;
    endtask

    // Offers one byte and returns #1 after the edge on which it was accepted.
    task automatic send_byte(input int k, input logic [7:0] b);
        int n;
        n = 0;
        bv_v[k] = 1'b1;
        bd_v[k] = b;
        @(negedge clk);
        while (!ready_v[k] && n < 64) begin
            n++;
            @(negedge clk);
        end
        if (!ready_v[k]) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout k=%0d byte_ready=%b required 1", k, ready_v[k]);
        end
        @(posedge clk);
        #1;
        bv_v[k] = 1'b0;
    endtask

    task automatic send_word(input int k, input logic [31:0] w, input bit be);
        logic [31:0] t;
        for (int i = 0; i < 4; i++) begin
            t = be ? (w >> (24 - 8 * i)) : (w >> (8 * i));
            send_byte(k, t[7:0]);
        end
    endtask

    // Called in the WRITE cycle of the last word; returns in DONE.
    task automatic finish_image(input int k, input logic [31:0] sum, input bit be);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(k, sum, be);
`else
        if (sum == 32'hffff_ffff && be) tick();
        tick();
`endif
    endtask

    task automatic test_reset();
        rst_v   = 3'b111;
        start_v = 3'b000;
        bv_v    = 3'b000;
        for (int k = 0; k < 3; k++) bd_v[k] = 8'h00;
        tick();
        tick();
        tick();
        if ({we_v, ready_v, busy_v, done_v, error_v} !== 15'd0) begin
            errors++;
            $display("FAIL reset_flags got %b required 0", {we_v, ready_v, busy_v, done_v, error_v});
        end
        checks++;
        for (int k = 0; k < 3; k++) begin
            if (wa_v[k] !== 6'd0 || wd_v[k] !== 32'd0) begin
                errors++;
                $display("FAIL reset_wa_wd k=%0d got %h/%h required 0/0", k, wa_v[k], wd_v[k]);
            end
            checks++;
        end
        rst_v = 3'b000;
        tick();
        if ({busy_v, done_v, ready_v} !== 9'd0) begin
            errors++;
            $display("FAIL post_reset_idle got %b required 0", {busy_v, done_v, ready_v});
        end
        checks++;
    endtask

    task automatic test_big_endian();
        log0.delete();
        pulse_start(0);
        if (busy_v[0] !== 1'b1 || ready_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL be_collect busy/ready got %b%b required 11", busy_v[0], ready_v[0]);
        end
        checks++;
        send_byte(0, 8'h12); send_byte(0, 8'h34); send_byte(0, 8'h56); send_byte(0, 8'h78);
        if (we_v[0] !== 1'b1 || wa_v[0] !== 6'd0 || wd_v[0] !== 32'h12345678 || ready_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL be_word0 got we=%b wa=%0d wd=%h rdy=%b required 1 0 12345678 0",
                     we_v[0], wa_v[0], wd_v[0], ready_v[0]);
        end
        checks++;
        send_byte(0, 8'hAA); send_byte(0, 8'hBB); send_byte(0, 8'hCC); send_byte(0, 8'hDD);
        if (we_v[0] !== 1'b1 || wa_v[0] !== 6'd1 || wd_v[0] !== 32'hAABBCCDD) begin
            errors++;
            $display("FAIL be_word1 got we=%b wa=%0d wd=%h required 1 1 aabbccdd",
                     we_v[0], wa_v[0], wd_v[0]);
        end
        checks++;
        finish_image(0, 32'hBCF02355, 1'b1);
        if ({done_v[0], busy_v[0], we_v[0], error_v[0]} !== 4'b1000) begin
            errors++;
            $display("FAIL be_done got done/busy/we/err=%b required 1000",
                     {done_v[0], busy_v[0], we_v[0], error_v[0]});
        end
        checks++;
        if (wa_v[0] !== 6'd1 || wd_v[0] !== 32'hAABBCCDD || log0.size() != 2) begin
            errors++;
            $display("FAIL be_hold got wa=%0d wd=%h writes=%0d required 1 aabbccdd 2",
                     wa_v[0], wd_v[0], log0.size());
        end
        checks++;
    endtask

    task automatic test_little_endian();
        pulse_start(1);
        send_byte(1, 8'h12); send_byte(1, 8'h34); send_byte(1, 8'h56); send_byte(1, 8'h78);
        if (we_v[1] !== 1'b1 || wa_v[1] !== 6'd0 || wd_v[1] !== 32'h78563412) begin
            errors++;
            $display("FAIL le_word0 got we=%b wa=%0d wd=%h required 1 0 78563412",
                     we_v[1], wa_v[1], wd_v[1]);
        end
        checks++;
        send_byte(1, 8'h9A); send_byte(1, 8'hBC); send_byte(1, 8'hDE); send_byte(1, 8'hF0);
        if (we_v[1] !== 1'b1 || wa_v[1] !== 6'd1 || wd_v[1] !== 32'hF0DEBC9A) begin
            errors++;
            $display("FAIL le_word1 got we=%b wa=%0d wd=%h required 1 1 f0debc9a",
                     we_v[1], wa_v[1], wd_v[1]);
        end
        checks++;
        finish_image(1, 32'h6934F0AC, 1'b0);
        if (done_v[1] !== 1'b1 || log1.size() != 2) begin
            errors++;
            $display("FAIL le_done got done=%b writes=%0d required 1 2", done_v[1], log1.size());
        end
        checks++;
    endtask

    task automatic test_start_handling();
        bit seen_ready;
        seen_ready = 1'b0;
        bv_v[0] = 1'b1;
        bd_v[0] = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ready_v[0]) seen_ready = 1'b1;
        end
        tick();
        bv_v[0] = 1'b0;
        if (seen_ready !== 1'b0 || log0.size() != 2 || done_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL done_ignores_bytes got rdy_seen=%b writes=%0d done=%b required 0 2 1",
                     seen_ready, log0.size(), done_v[0]);
        end
        checks++;
        pulse_start(0);
        if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL restart_from_done got done=%b busy=%b required 0 1", done_v[0], busy_v[0]);
        end
        checks++;
        send_byte(0, 8'h01);
        pulse_start(0);
        send_byte(0, 8'h02); send_byte(0, 8'h03); send_byte(0, 8'h04);
        if (we_v[0] !== 1'b1 || wa_v[0] !== 6'd0 || wd_v[0] !== 32'h01020304) begin
            errors++;
            $display("FAIL start_in_collect got we=%b wa=%0d wd=%h required 1 0 01020304",
                     we_v[0], wa_v[0], wd_v[0]);
        end
        checks++;
        send_word(0, 32'h05060708, 1'b1);
        finish_image(0, 32'h06080A0C, 1'b1);
        if (done_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL restart_done got done=%b required 1", done_v[0]);
        end
        checks++;
    endtask

    task automatic test_gapped_valid();
        logic [7:0] bytes [8];
        bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        log0.delete();
        ready_in_write = 0;
        pulse_start(0);
        for (int i = 0; i < 8; i++) begin
            send_byte(0, bytes[i]);
            tick();
        end
        finish_image(0, 32'hBCF02355, 1'b1);
        if (log0.size() != 2) begin
            errors++;
            $display("FAIL gap_write_count got %0d required 2", log0.size());
        end else begin
            if (log0[0] !== {6'd0, 32'h12345678} || log0[1] !== {6'd1, 32'hAABBCCDD}) begin
                errors++;
                $display("FAIL gap_write_data got %h %h required 0012345678 01aabbccdd",
                         log0[0], log0[1]);
            end
            checks++;
        end
        checks++;
        if (ready_in_write != 0 || done_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL gap_ready_in_write got %0d done=%b required 0 1",
                     ready_in_write, done_v[0]);
        end
        checks++;
    endtask

    task automatic test_reset_mid_word();
        log0.delete();
        pulse_start(0);
        send_word(0, 32'h11223344, 1'b1);
        send_byte(0, 8'h55);
        send_byte(0, 8'h66);
        rst_v[0] = 1'b1;
        tick();
        tick();
        if ({we_v[0], busy_v[0], ready_v[0], done_v[0]} !== 4'b0000
            || wa_v[0] !== 6'd0 || wd_v[0] !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset got flags=%b wa=%0d wd=%h required 0000 0 0",
                     {we_v[0], busy_v[0], ready_v[0], done_v[0]}, wa_v[0], wd_v[0]);
        end
        checks++;
        rst_v[0] = 1'b0;
        tick();
        pulse_start(0);
        send_word(0, 32'hA1B2C3D4, 1'b1);
        send_word(0, 32'h0F1E2D3C, 1'b1);
        finish_image(0, 32'hB0D0F110, 1'b1);
        if (log0.size() != 3) begin
            errors++;
            $display("FAIL mid_reset_writes got %0d required 3", log0.size());
        end else begin
            if (log0[0] !== {6'd0, 32'h11223344} || log0[1] !== {6'd0, 32'hA1B2C3D4}
                || log0[2] !== {6'd1, 32'h0F1E2D3C}) begin
                errors++;
                $display("FAIL mid_reset_data got %h %h %h required 0011223344 00a1b2c3d4 010f1e2d3c",
                         log0[0], log0[1], log0[2]);
            end
            checks++;
        end
        checks++;
    endtask

    task automatic test_full_image();
        logic [31:0] sum;
        logic [31:0] exp;
        logic [7:0]  b;
        bit          seen_ready;
        sum = 32'd0;
        log2.delete();
        pulse_start(2);
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            send_byte(2, b);
        end
        for (int j = 0; j < 64; j++) begin
            exp = {8'(4 * j), 8'(4 * j + 1), 8'(4 * j + 2), 8'(4 * j + 3)};
            sum = sum + exp;
        end
        finish_image(2, sum, 1'b1);
        if (log2.size() != 64 || done_v[2] !== 1'b1) begin
            errors++;
            $display("FAIL full_count got writes=%0d done=%b required 64 1", log2.size(), done_v[2]);
        end
        checks++;
        for (int j = 0; j < 64 && j < log2.size(); j++) begin
            exp = {8'(4 * j), 8'(4 * j + 1), 8'(4 * j + 2), 8'(4 * j + 3)};
            if (log2[j] !== {6'(j), exp}) begin
                errors++;
                $display("FAIL full_word%0d got %h required %h", j, log2[j], {6'(j), exp});
            end
            checks++;
        end
        seen_ready = 1'b0;
        bv_v[2] = 1'b1;
        bd_v[2] = 8'hEE;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ready_v[2]) seen_ready = 1'b1;
        end
        tick();
        bv_v[2] = 1'b0;
        if (seen_ready !== 1'b0 || log2.size() != 64 || done_v[2] !== 1'b1) begin
            errors++;
            $display("FAIL full_extra_bytes got rdy_seen=%b writes=%0d done=%b required 0 64 1",
                     seen_ready, log2.size(), done_v[2]);
        end
        checks++;
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        pulse_start(0);
        send_word(0, 32'h00000001, 1'b1);
        send_word(0, 32'h00000002, 1'b1);
        send_word(0, 32'h00000003, 1'b1);
        if (done_v[0] !== 1'b1 || error_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL csum_good got done=%b err=%b required 1 0", done_v[0], error_v[0]);
        end
        checks++;
        pulse_start(0);
        send_word(0, 32'h00000001, 1'b1);
        send_word(0, 32'h00000002, 1'b1);
        send_word(0, 32'h00000004, 1'b1);
        if (done_v[0] !== 1'b1 || error_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL csum_bad got done=%b err=%b required 1 1", done_v[0], error_v[0]);
        end
        checks++;
        pulse_start(0);
        if (error_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL csum_clear_on_start got err=%b required 0", error_v[0]);
        end
        checks++;
        send_word(0, 32'h00000001, 1'b1);
        send_word(0, 32'h00000002, 1'b1);
        send_word(0, 32'h00000003, 1'b1);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got no finish required finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_big_endian();
        test_little_endian();
        test_start_handling();
        test_gapped_valid();
        test_reset_mid_word();
        test_full_image();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The module SHALL take parameter NWORDS, default 64, the number of 32-bit words loaded per image (1..64).
REQ-002 The module SHALL take parameter BIG_ENDIAN, default 1: first byte of a word goes to bits 31:24 (1) or 7:0 (0).
REQ-003 The module SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The module SHALL have port start, input, 1, a one-cycle pulse that begins a load.
REQ-006 The module SHALL have port byte_valid, input, 1, meaning byte_data is offered.
REQ-007 The module SHALL have port byte_data, input, 8, the image byte stream.
REQ-008 The module SHALL have port byte_ready, output, 1; a byte transfers on a cycle with byte_valid and byte_ready both high.
REQ-009 The module SHALL have port we, output, 1, the instruction-memory write enable.
REQ-010 The module SHALL have port wa, output, 6, the word address for the write.
REQ-011 The module SHALL have port wd, output, 32, the word data for the write.
REQ-012 The module SHALL have port busy, output, 1, high in COLLECT, WRITE and CHECK.
REQ-013 The module SHALL have port done, output, 1, high in DONE.
REQ-014 The module SHALL have port error, output, 1, the checksum mismatch flag.

Function
REQ-015 The module SHALL implement states IDLE, COLLECT, WRITE, CHECK and DONE.
REQ-016 IDLE SHALL go to COLLECT on start and clear the word counter, byte counter and checksum accumulator on that transition.
REQ-017 byte_ready SHALL be high only in COLLECT and CHECK; no byte transfers in IDLE, WRITE or DONE.
REQ-018 In COLLECT, each accepted byte SHALL be placed into the assembly register at the lane set by the byte counter (0..3) and BIG_ENDIAN.
REQ-019 On the 4th accepted byte the FSM SHALL enter WRITE; WRITE SHALL last exactly one cycle with we=1, wa=word counter, wd=assembled word.
REQ-020 Latency from the 4th byte handshake to we high SHALL be exactly one cycle.
REQ-021 After WRITE, the word counter SHALL increment; if the written word was NWORDS-1, the FSM SHALL go to CHECK (macro defined) or DONE (macro undefined), else back to COLLECT.
REQ-022 we SHALL be 0 in every state except WRITE; wa and wd SHALL hold their last values outside WRITE.
REQ-023 The word counter SHALL never wrap: no write to an address at or above NWORDS.
REQ-024 start outside IDLE and DONE SHALL be ignored; start in DONE SHALL behave as in IDLE and clear error.
REQ-025 byte_valid with byte_ready low SHALL be ignored, with no state change.
REQ-026 DONE SHALL hold until start or reset.

Reset
REQ-027 On reset the FSM SHALL enter IDLE regardless of state, including mid-word or mid-WRITE.
REQ-028 During and after reset: we=0, wa=0, wd=0, byte_ready=0, busy=0, done=0, error=0, all counters and the accumulator 0.
REQ-029 A partially assembled word SHALL be discarded on reset; already written words are not rewritten.

Configuration
REQ-030 With macro IMEM_LOADER_CHECKSUM_EN defined, every word written SHALL be added modulo 2^32 to an accumulator.
REQ-031 With IMEM_LOADER_CHECKSUM_EN defined, CHECK SHALL accept 4 trailer bytes, assembled like data words, with we held 0.
REQ-032 With IMEM_LOADER_CHECKSUM_EN defined, on the 4th trailer byte the FSM SHALL go to DONE and set error=1 if the trailer differs from the accumulator, else error=0.
REQ-033 With IMEM_LOADER_CHECKSUM_EN undefined, CHECK and the accumulator SHALL not exist, there SHALL be no trailer, and error SHALL be tied 0.

Verification
REQ-034 NWORDS=2, BIG_ENDIAN=1, macro off; start, bytes 12 34 56 78 AA BB CC DD -> we pulses with (wa=0, wd=12345678) and (wa=1, wd=AABBCCDD), then done=1.
REQ-035 BIG_ENDIAN=0; bytes 12 34 56 78 -> wd=78563412 at wa=0.
REQ-036 byte_valid toggled every other cycle -> same writes; no byte lost or duplicated; byte_ready=0 during WRITE.
REQ-037 reset after 2 bytes of word 1, then restart with 8 new bytes -> first write at wa=0 with new data; no write of the partial word.
REQ-038 Macro on, NWORDS=2, words 00000001 and 00000002, trailer 00000003 -> done=1, error=0; trailer 00000004 -> error=1.
REQ-039 NWORDS=64, 256 bytes -> 64 writes at wa 0..63, then done; extra bytes with byte_valid held high -> byte_ready stays 0 and no further we.
